// File: rtl/rom_rd_arbiter_if.sv
// ---------------------------------------------------------------------------
// rom_rd_arbiter_if
//   Requester-side bus of the ROM read arbiter: one valid/ready request
//   handshake plus a registered response pulse per requester.
//
//   req_valid [N_REQ]    requester -> arbiter  read pending, bit per requester
//   req_addr  [3*N_REQ]  requester -> arbiter  3-bit ROM address per requester
//   req_ready [N_REQ]    arbiter -> requester  request accepted this cycle
//   rsp_valid [N_REQ]    arbiter -> requester  one-cycle response pulse
//   rsp_data  [8]        arbiter -> requester  read data, shared by all
//
//   master : requester side, slave : arbiter side
// ---------------------------------------------------------------------------
interface rom_rd_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]   req_valid;
  logic [3*N_REQ-1:0] req_addr;
  logic [N_REQ-1:0]   req_ready;
  logic [N_REQ-1:0]   rsp_valid;
  logic [7:0]         rsp_data;

  modport master (
    output req_valid, req_addr,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/rom_rd_arbiter.sv
// ---------------------------------------------------------------------------
// rom_rd_arbiter
//   Shares one 8-entry x 8-bit registered lookup ROM between N_REQ requesters.
//   Round-robin grant in IDLE, one ROM access in ISSUE, capture of the ROM
//   word in WAIT; the response pulse appears as the FSM returns to IDLE, so a
//   read takes 3 cycles from accept to response.
//
//   clk               in   clock, rising edge
//   rst               in   asynchronous active-high reset
//   bus               slave modport of rom_rd_arbiter_if (requester side)
//   rom_enable        out  ROM read enable, high only in ISSUE
//   rom_addr_oneshot  out  one-hot ROM address, always exactly one bit set
//   rom_dout          in   ROM data, registered inside the ROM (1 cycle)
// ---------------------------------------------------------------------------
module rom_rd_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rom_rd_arbiter_if.slave      bus,
  output logic                 rom_enable,
  output logic [7:0]           rom_addr_oneshot,
  input  logic [7:0]           rom_dout
);

  localparam int IW = $clog2(N_REQ);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] lat_idx;
  logic [2:0]    lat_addr;

  logic          found;
  logic [IW-1:0] winner;
  logic [2:0]    win_addr;
  logic          accept;

  // Round-robin search: first pass looks only above the last grant, second
  // pass wraps to the lowest index. This is the same order as counting up
  // from last_grant+1 modulo N_REQ, without needing a modulo operator.
  // NOTE: every variable driven here gets a default first so no latch is
  // inferred on the paths where no requester is valid.
  always_comb begin
    found    = 1'b0;
    winner   = '0;
    win_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req_valid[i] && (IW'(i) > last_grant)) begin
        found    = 1'b1;
        winner   = IW'(i);
        win_addr = bus.req_addr[3*i +: 3];
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && bus.req_valid[i]) begin
        found    = 1'b1;
        winner   = IW'(i);
        win_addr = bus.req_addr[3*i +: 3];
      end
    end
  end

  assign accept = (state == IDLE) && found;

  always_comb begin
    bus.req_ready = '0;
    if (accept) bus.req_ready[winner] = 1'b1;
  end

  assign rom_enable = (state == ISSUE);

  // lat_addr only changes on accept, so the one-hot code holds the last
  // issued address between reads and is 0x01 straight out of reset.
  assign rom_addr_oneshot = 8'h01 << lat_addr;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_grant    <= IW'(N_REQ - 1);
      lat_idx       <= '0;
      lat_addr      <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_data  <= '0;
    end else begin
      bus.rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_idx    <= winner;
            lat_addr   <= win_addr;
            last_grant <= winner;
            state      <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          bus.rsp_data           <= rom_dout;
          bus.rsp_valid[lat_idx] <= 1'b1;
          state                  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_rd_arbiter
//   Directed bench for rom_rd_arbiter with N_REQ = 4 and a behavioural model
//   of the registered ROM (address k returns 0x11*(k+1)). A per-cycle vector
//   table covers reset exit, round-robin and a single read; hand sequences
//   cover back-to-back rotation, withdrawal and reset in mid-read.
// ---------------------------------------------------------------------------
module tb_rom_rd_arbiter;

  localparam int N_REQ = 4;

  logic       clk;
  logic       rst;
  logic       rom_enable;
  logic [7:0] rom_addr_oneshot;
  logic [7:0] rom_dout;

  int n_checks = 0;
  int n_fail   = 0;

  rom_rd_arbiter_if #(.N_REQ(N_REQ)) bus ();

  rom_rd_arbiter #(.N_REQ(N_REQ)) dut (
    .clk              (clk),
    .rst              (rst),
    .bus              (bus),
    .rom_enable       (rom_enable),
    .rom_addr_oneshot (rom_addr_oneshot),
    .rom_dout         (rom_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: registered output, zero when not enabled, 0xEE flags an
  // illegal (non-one-hot) address.
  function automatic logic [7:0] rom_lookup(input logic [7:0] oh);
    logic [7:0] r;
    r = 8'hEE;
    for (int k = 0; k < 8; k++)
      if (oh == (8'h01 << k)) r = 8'(8'h11 * (k + 1));
    return r;
  endfunction

  initial rom_dout = 8'h00;
  always_ff @(posedge clk)
    rom_dout <= rom_enable ? rom_lookup(rom_addr_oneshot) : 8'h00;

  typedef struct {
    logic [3:0]  valid;
    logic [11:0] addr;
    logic [3:0]  ready;
    logic [3:0]  rsp_v;
    logic [7:0]  data;
    logic        en;
    logic [7:0]  os;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic [3:0] valid, input logic [11:0] addr,
                              input logic [3:0] ready, input logic [3:0] rsp_v,
                              input logic [7:0] data, input logic en,
                              input logic [7:0] os);
    vec_t v;
    v.valid = valid; v.addr = addr; v.ready = ready; v.rsp_v = rsp_v;
    v.data = data; v.en = en; v.os = os;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic [3:0] ready,
                             input logic [3:0] rsp_v, input logic [7:0] data,
                             input logic en, input logic [7:0] os);
    #1;
    check({tag, " req_ready"},        32'(bus.req_ready),   32'(ready));
    check({tag, " rsp_valid"},        32'(bus.rsp_valid),   32'(rsp_v));
    check({tag, " rsp_data"},         32'(bus.rsp_data),    32'(data));
    check({tag, " rom_enable"},       32'(rom_enable),      32'(en));
    check({tag, " rom_addr_oneshot"}, 32'(rom_addr_oneshot), 32'(os));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_addr(input int idx, input logic [2:0] a);
    bus.req_addr[3*idx +: 3] = a;
  endtask

  localparam logic [11:0] RR_ADDR = {3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [11:0] A2_5    = {3'd0, 3'd5, 3'd0, 3'd0};

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_addr  = '0;

    // Round-robin with all four valid from a fresh pointer (N_REQ-1).
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0001, 4'b0000, 8'h00, 1'b0, 8'h01));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0000, 4'b0000, 8'h00, 1'b1, 8'h01));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h01));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0010, 4'b0001, 8'h11, 1'b0, 8'h01));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0000, 4'b0000, 8'h11, 1'b1, 8'h02));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0000, 4'b0000, 8'h11, 1'b0, 8'h02));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0100, 4'b0010, 8'h22, 1'b0, 8'h02));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0000, 4'b0000, 8'h22, 1'b1, 8'h04));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0000, 4'b0000, 8'h22, 1'b0, 8'h04));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b1000, 4'b0100, 8'h33, 1'b0, 8'h04));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0000, 4'b0000, 8'h33, 1'b1, 8'h08));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0000, 4'b0000, 8'h33, 1'b0, 8'h08));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0001, 4'b1000, 8'h44, 1'b0, 8'h08));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0000, 4'b0000, 8'h44, 1'b1, 8'h01));
    vq.push_back(mk(4'b1111, RR_ADDR, 4'b0000, 4'b0000, 8'h44, 1'b0, 8'h01));
    vq.push_back(mk(4'b0000, RR_ADDR, 4'b0000, 4'b0001, 8'h11, 1'b0, 8'h01));
    vq.push_back(mk(4'b0000, RR_ADDR, 4'b0000, 4'b0000, 8'h11, 1'b0, 8'h01));
    // Single read: requester 2, address 5.
    vq.push_back(mk(4'b0100, A2_5,    4'b0100, 4'b0000, 8'h11, 1'b0, 8'h01));
    vq.push_back(mk(4'b0000, A2_5,    4'b0000, 4'b0000, 8'h11, 1'b1, 8'h20));
    vq.push_back(mk(4'b0000, A2_5,    4'b0000, 4'b0000, 8'h11, 1'b0, 8'h20));
    vq.push_back(mk(4'b0000, A2_5,    4'b0000, 4'b0100, 8'h66, 1'b0, 8'h20));
    vq.push_back(mk(4'b0000, A2_5,    4'b0000, 4'b0000, 8'h66, 1'b0, 8'h20));

    // Reset state, checked while reset is held and across clock edges.
    #3;
    expect_outs("reset", 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h01);
    tick();
    tick();
    expect_outs("reset held", 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h01);
    rst = 1'b0;

    foreach (vq[i]) begin
      bus.req_valid = vq[i].valid;
      bus.req_addr  = vq[i].addr;
      expect_outs($sformatf("vec%0d", i), vq[i].ready, vq[i].rsp_v,
                  vq[i].data, vq[i].en, vq[i].os);
      tick();
    end

    // Back-to-back rotation: requester 1 reads first (pointer -> 1), then
    // requester 3 waits and requester 1 re-requests in its response cycle.
    bus.req_addr = '0;
    bus.req_valid = 4'b0010; set_addr(1, 3'd0);
    expect_outs("b2b accept r1", 4'b0010, 4'b0000, 8'h66, 1'b0, 8'h20);
    tick();
    bus.req_valid = 4'b1000; set_addr(3, 3'd4);
    expect_outs("b2b issue r1", 4'b0000, 4'b0000, 8'h66, 1'b1, 8'h01);
    tick();
    expect_outs("b2b wait r1", 4'b0000, 4'b0000, 8'h66, 1'b0, 8'h01);
    tick();
    bus.req_valid = 4'b1010; set_addr(1, 3'd7);
    expect_outs("b2b rsp r1 grant r3", 4'b1000, 4'b0010, 8'h11, 1'b0, 8'h01);
    tick();
    bus.req_valid = 4'b0010;
    expect_outs("b2b issue r3", 4'b0000, 4'b0000, 8'h11, 1'b1, 8'h10);
    tick();
    expect_outs("b2b wait r3", 4'b0000, 4'b0000, 8'h11, 1'b0, 8'h10);
    tick();
    expect_outs("b2b rsp r3 grant r1", 4'b0010, 4'b1000, 8'h55, 1'b0, 8'h10);
    tick();
    bus.req_valid = 4'b0000;
    expect_outs("b2b issue r1 again", 4'b0000, 4'b0000, 8'h55, 1'b1, 8'h80);
    tick();
    expect_outs("b2b wait r1 again", 4'b0000, 4'b0000, 8'h55, 1'b0, 8'h80);
    tick();
    expect_outs("b2b rsp r1 0x88", 4'b0000, 4'b0010, 8'h88, 1'b0, 8'h80);
    tick();
    expect_outs("b2b pulse ends", 4'b0000, 4'b0000, 8'h88, 1'b0, 8'h80);
    tick();

    // Withdrawal: requester 0 is valid only while the arbiter is busy.
    bus.req_valid = 4'b0100; set_addr(2, 3'd1);
    expect_outs("wd accept r2", 4'b0100, 4'b0000, 8'h88, 1'b0, 8'h80);
    tick();
    bus.req_valid = 4'b0001; set_addr(0, 3'd6);
    expect_outs("wd r0 raised in issue", 4'b0000, 4'b0000, 8'h88, 1'b1, 8'h02);
    tick();
    expect_outs("wd r0 in wait", 4'b0000, 4'b0000, 8'h88, 1'b0, 8'h02);
    bus.req_valid = 4'b0000;
    tick();
    expect_outs("wd rsp r2", 4'b0000, 4'b0100, 8'h22, 1'b0, 8'h02);
    for (int c = 0; c < 3; c++) begin
      tick();
      expect_outs($sformatf("wd idle%0d", c), 4'b0000, 4'b0000, 8'h22, 1'b0, 8'h02);
    end
    tick();

    // Reset during WAIT of a read to address 3, then a clean re-read.
    bus.req_valid = 4'b0001; set_addr(0, 3'd3);
    expect_outs("mr accept r0", 4'b0001, 4'b0000, 8'h22, 1'b0, 8'h02);
    tick();
    bus.req_valid = 4'b0000;
    expect_outs("mr issue", 4'b0000, 4'b0000, 8'h22, 1'b1, 8'h08);
    tick();
    expect_outs("mr wait", 4'b0000, 4'b0000, 8'h22, 1'b0, 8'h08);
    rst = 1'b1;
    expect_outs("mr reset async", 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h01);
    tick();
    expect_outs("mr no response", 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h01);
    rst = 1'b0;
    bus.req_valid = 4'b0001;
    expect_outs("mr re-accept", 4'b0001, 4'b0000, 8'h00, 1'b0, 8'h01);
    tick();
    bus.req_valid = 4'b0000;
    expect_outs("mr re-issue", 4'b0000, 4'b0000, 8'h00, 1'b1, 8'h08);
    tick();
    expect_outs("mr re-wait", 4'b0000, 4'b0000, 8'h00, 1'b0, 8'h08);
    tick();
    expect_outs("mr re-rsp 0x44", 4'b0000, 4'b0001, 8'h44, 1'b0, 8'h08);
    tick();
    expect_outs("mr pulse ends", 4'b0000, 4'b0000, 8'h44, 1'b0, 8'h08);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_rd_arbiter.md
# rom_rd_arbiter

Shares the 8-entry, 8-bit lookup ROM (`rom_ctrl`) between up to `N_REQ` independent requesters. The arbiter performs round-robin arbitration and a valid/ready request handshake. It converts each granted 3-bit address into the ROM's one-hot address and drives the ROM `enable`. It then captures the ROM's registered output and returns it to the winning requester with a one-cycle response pulse. It sits between requester logic and a single `rom_ctrl` instance, and is the only driver of that instance's inputs.

## Interface
- `N_REQ`, default 4: number of requesters, legal range 2..8.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  bit i is high while requester i has a read pending.
- `req_addr`  in  3*N_REQ  bits [3i+2:3i] are requester i's ROM address (0..7).
- `req_ready`  out  N_REQ  bit i is high when requester i's request is accepted this cycle. Combinational.
- `rsp_valid`  out  N_REQ  bit i is a one-cycle pulse marking `rsp_data` valid for requester i. Registered.
- `rsp_data`  out  8  read data; valid only while some `rsp_valid` bit is high. Registered.
- `rom_enable`  out  1  to `rom_ctrl.enable`.
- `rom_addr_oneshot`  out  8  to `rom_ctrl.addr_oneshot`. Always exactly one-hot.
- `rom_dout`  in  8  from `rom_ctrl.dout`. Registered inside the ROM, 1-cycle latency.

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- **IDLE**
  - If any `req_valid` bit is high, select a winner by round-robin.
  - Assert `req_ready[winner]` only; all other ready bits stay 0.
  - Latch the winner's index and `req_addr` slice.
  - Update the last-grant pointer to the winner.
  - Go to ISSUE.
  - With no `req_valid` bits high, stay in IDLE with `req_ready` = 0.
- **ISSUE**
  - Drive `rom_enable` = 1 and `rom_addr_oneshot` = 1 << latched addr.
  - Go to WAIT.
- **WAIT**
  - `rom_dout` now holds the ROM word.
  - On this edge, register `rsp_data` <= `rom_dout` and `rsp_valid` <= one-hot of the latched index.
  - Go to IDLE.
- **Round-robin rule:** search starts at (last grant + 1) mod N_REQ and increments with wrap; the first high `req_valid` bit wins.
  - The reset value of the last-grant pointer is N_REQ-1, so requester 0 has top priority after reset.
- **`req_ready` gating:** never asserted outside IDLE. Handshake completes when valid and ready are both high. A requester must hold `req_valid` and `req_addr` stable until accepted; dropping `req_valid` before acceptance withdraws the request with no side effects.
- **`rom_addr_oneshot` outside ISSUE:** holds the last issued one-hot value (never 0x00), so the ROM's address decode never sees a non-one-hot code.
- **`rom_enable` outside ISSUE:** 0. The ROM therefore outputs 0x00 in those cycles; `rom_dout` is sampled only in WAIT.
- **`rsp_valid` / `rsp_data`:** `rsp_valid` deasserts after one cycle. `rsp_data` holds its value until the next response.
- **Same address from several requesters:** each request is serviced independently; no result merging.
- **Reset mid-operation:** immediate return to IDLE. The in-flight request is dropped with no response; the requester must re-request.

## Timing
- **Reset values:**
  - state = IDLE.
  - `req_ready` = 0 (combinational from IDLE with no valid requests).
  - `rsp_valid` = 0.
  - `rsp_data` = 0x00.
  - `rom_enable` = 0.
  - `rom_addr_oneshot` = 0x01.
  - Latched addr = 0, latched index = 0.
  - Last-grant pointer = N_REQ-1.
- **Request cycle sequence:**
  - Cycle 0: accept (`req_ready` high).
  - Cycle 1: ISSUE (`rom_enable` high).
  - Cycle 2: WAIT (`rom_dout` valid).
  - Cycle 3: `rsp_valid`/`rsp_data` valid, and IDLE again, so a new request may be accepted in the same cycle.
- **Latency:** 3 cycles from accept to response.
- **Throughput:** one read per 3 cycles.
- **Worst-case wait:** with all N_REQ requesters continuously valid, a requester is granted at most 3*(N_REQ-1) cycles after becoming valid. No starvation.

## Test plan
ROM contents: address k returns 0x11*(k+1).

- **Reset state:** assert `rst` → `rom_enable`=0, `rom_addr_oneshot`=0x01, `rsp_valid`=0, `rsp_data`=0x00, `req_ready`=0.
- **Single read:** requester 2 reads addr 5 → `req_ready[2]` high in cycle 0; `rom_enable`=1 and `rom_addr_oneshot`=0x20 in cycle 1; `rsp_valid`=0b0100 and `rsp_data`=0x66 in cycle 3, for exactly one cycle.
- **Round-robin fairness:** all 4 requesters hold valid, with addrs 0,1,2,3 → grants in order 0,1,2,3,0; responses 0x11, 0x22, 0x33, 0x44 spaced 3 cycles apart.
- **Back-to-back rotation:** requester 1 asserts valid in the same cycle its response arrives (addr 7), while requester 3 also waits → requester 3 wins first (pointer at 1). Requester 1 then receives 0x88 six cycles later.
- **Withdrawal:** requester 0 raises `req_valid` while the arbiter is busy, then drops it before IDLE → no `req_ready[0]`, no `rsp_valid[0]`, no ROM access.
- **Reset mid-operation:** assert `rst` during WAIT of a read to addr 3 → no `rsp_valid`, all outputs at reset values. After release, a new read of addr 3 returns 0x44 with normal 3-cycle latency.
